pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register: the next generation of the per-stage D/E-style latches, replacing ad-hoc stall/flush wiring with a valid/ready handshake. It carries one generic payload bus (the stage bundle, concatenated by the instantiating stage) and holds it for one cycle. An optional two-entry skid mode registers the upstream ready path, so the stall chain no longer ripples combinationally across stages. It sits between any two pipeline stages of the CPU (F/D, D/E, E/M, M/W).

---
 rtl/pipe_stage_buf.sv | 79 +++++++
 tb/tb_pipe_stage_buf.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake and an optional two-entry skid buffer.
// With SKID=1 in_ready is registered state, so stalls do not ripple combinationally upstream.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  localparam bit UseSkid = (SKID != 0);

  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic in_fire;
  logic out_fire;

  assign in_ready  = UseSkid ? (~skid_valid_q & ~rst) : ((~main_valid_q | out_ready) & ~rst);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;
  assign out_fire  = out_valid & out_ready;
  assign occ       = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // The skid entry is only ever filled while main is held, so it is always the younger item.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (!main_valid_q) begin
      if (in_fire) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end
    end else if (out_fire) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        skid_data_d  = '0;
      end else if (in_fire) begin
        main_data_d = in_data;
      end else begin
        main_valid_d = 1'b0;
        main_data_d  = '0;
      end
    end else if (in_fire && UseSkid) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // Empty slots are kept at zero so a bubble presents an all-zero bundle.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= UseSkid & skid_valid_d;
      skid_data_q  <= UseSkid ? skid_data_d : '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: one SKID=1 and one SKID=0 instance, plus a short
// randomised handshake run checked against a queue model.
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_data, s_out_data;
  logic [1:0]  s_occ;

  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [31:0] n_in_data, n_out_data;
  logic [1:0]  n_occ;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sq[$];
  logic [31:0] nq[$];
  logic        s_stall_prev = 1'b0;
  logic        n_stall_prev = 1'b0;
  logic [31:0] s_prev_data, n_prev_data;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(32), .SKID(1)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_data   (s_in_data),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .occ       (s_occ)
  );

  pipe_stage_buf #(.DATA_W(32), .SKID(0)) u_noskid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (n_in_valid),
    .in_ready  (n_in_ready),
    .in_data   (n_in_data),
    .out_valid (n_out_valid),
    .out_ready (n_out_ready),
    .out_data  (n_out_data),
    .occ       (n_occ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(input bit drain);
    logic s_rdy_exp, n_rdy_exp;
    s_in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
    s_in_data   = $urandom;
    s_out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    n_in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
    n_in_data   = $urandom;
    n_out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    #1;
    s_rdy_exp = (sq.size() < 2);
    n_rdy_exp = (nq.size() == 0) || n_out_ready;
    chk("s_rnd_in_ready", s_in_ready, s_rdy_exp);
    chk("s_rnd_valid", s_out_valid, sq.size() != 0);
    if (s_out_valid && sq.size() != 0) chk("s_rnd_data", s_out_data, sq[0]);
    if (s_stall_prev) chk("s_rnd_stable", s_out_data, s_prev_data);
    chk("n_rnd_in_ready", n_in_ready, n_rdy_exp);
    chk("n_rnd_valid", n_out_valid, nq.size() != 0);
    if (n_out_valid && nq.size() != 0) chk("n_rnd_data", n_out_data, nq[0]);
    if (n_stall_prev) chk("n_rnd_stable", n_out_data, n_prev_data);
    if (sq.size() != 0 && s_out_ready) void'(sq.pop_front());
    if (s_in_valid && s_rdy_exp) sq.push_back(s_in_data);
    if (nq.size() != 0 && n_out_ready) void'(nq.pop_front());
    if (n_in_valid && n_rdy_exp) nq.push_back(n_in_data);
    s_stall_prev = s_out_valid & ~s_out_ready;
    s_prev_data  = s_out_data;
    n_stall_prev = n_out_valid & ~n_out_ready;
    n_prev_data  = n_out_data;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
    #1;
    chk("rst_in_ready", s_in_ready, 0);
    tick(); tick();
    chk("rst_out_valid", s_out_valid, 0);
    chk("rst_out_data", s_out_data, 0);
    chk("rst_occ", s_occ, 0);
    chk("rst_n_in_ready", n_in_ready, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", s_in_ready, 1);
    chk("post_rst_n_in_ready", n_in_ready, 1);

    // Streaming through the skid stage
    s_out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_in_valid = 1'b1;
      s_in_data  = i;
      tick();
      chk("stream_data", s_out_data, i);
      chk("stream_valid", s_out_valid, 1);
      chk("stream_occ", s_occ, 1);
      chk("stream_in_ready", s_in_ready, 1);
    end
    s_in_valid = 1'b0;
    tick();
    chk("stream_end_occ", s_occ, 0);

    // Skid fill and drain
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1; s_in_data = 32'hA;
    tick();
    chk("fill1_occ", s_occ, 1);
    chk("fill1_in_ready", s_in_ready, 1);
    s_in_data = 32'hB;
    tick();
    chk("fill2_occ", s_occ, 2);
    chk("fill2_in_ready", s_in_ready, 0);
    chk("fill2_data", s_out_data, 32'hA);
    s_in_valid = 1'b0;
    tick();
    chk("hold_data", s_out_data, 32'hA);
    chk("hold_occ", s_occ, 2);
    s_out_ready = 1'b1;
    tick();
    chk("drain1_data", s_out_data, 32'hB);
    chk("drain1_occ", s_occ, 1);
    chk("drain1_in_ready", s_in_ready, 1);
    tick();
    chk("drain2_occ", s_occ, 0);
    chk("drain2_valid", s_out_valid, 0);
    chk("drain2_data", s_out_data, 0);

    // Flush beats simultaneous in_fire and out_fire
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1; s_in_data = 32'hC;
    tick();
    s_in_data = 32'hD;
    tick();
    chk("pre_flush_occ", s_occ, 2);
    flush = 1'b1; s_in_valid = 1'b1; s_in_data = 32'hE; s_out_ready = 1'b1;
    tick();
    chk("flush_valid", s_out_valid, 0);
    chk("flush_data", s_out_data, 0);
    chk("flush_occ", s_occ, 0);
    chk("flush_in_ready", s_in_ready, 1);
    flush = 1'b0; s_in_data = 32'hF;
    tick();
    chk("after_flush_data", s_out_data, 32'hF);
    chk("after_flush_valid", s_out_valid, 1);
    s_in_valid = 1'b0;
    tick();
    chk("after_flush_empty", s_occ, 0);

    // Reset while full
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1; s_in_data = 32'h11;
    tick();
    s_in_data = 32'h22;
    tick();
    chk("pre_rst_occ", s_occ, 2);
    s_in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", s_in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_valid", s_out_valid, 0);
    chk("rst2_data", s_out_data, 0);
    chk("rst2_occ", s_occ, 0);
    chk("rst2_in_ready", s_in_ready, 1);

    // SKID=0: combinational in_ready follows out_ready while main is full
    n_out_ready = 1'b0;
    n_in_valid  = 1'b1; n_in_data = 32'h55;
    tick();
    chk("n_load_data", n_out_data, 32'h55);
    chk("n_load_occ", n_occ, 1);
    n_in_data = 32'h66;
    #1;
    chk("n_stall_in_ready", n_in_ready, 0);
    tick();
    chk("n_stall_hold", n_out_data, 32'h55);
    n_out_ready = 1'b1;
    #1;
    chk("n_release_in_ready", n_in_ready, 1);
    tick();
    chk("n_release_data", n_out_data, 32'h66);
    chk("n_release_occ", n_occ, 1);
    for (int i = 0; i < 3; i++) begin
      n_in_data = 32'h70 + i;
      tick();
      chk("n_stream_data", n_out_data, 32'h70 + i);
    end
    n_in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("n_flush_valid", n_out_valid, 0);
    chk("n_flush_occ", n_occ, 0);

    // Randomised handshakes against a queue model, then drain
    s_stall_prev = 1'b0;
    n_stall_prev = 1'b0;
    for (int i = 0; i < 1500; i++) rand_cycle(1'b0);
    for (int i = 0; i < 4; i++) rand_cycle(1'b1);
    chk("s_final_occ", s_occ, 0);
    chk("n_final_occ", n_occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
